// File: rtl/dm_req_if.sv
// Request/response handshake between the MEM stage and the
// data-memory access controller.
interface dm_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid,
    input  req_ready,
    output req_we,
    output req_size,
    output req_unsigned,
    output req_addr,
    output req_wdata,
    input  resp_valid,
    input  resp_err,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_we,
    input  req_size,
    input  req_unsigned,
    input  req_addr,
    input  req_wdata,
    output resp_valid,
    output resp_err,
    output resp_rdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores,
// read-modify-write for sub-word stores, misalignment trap.
module dm_access_ctrl #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_req_if.slave       bus,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic          dm_we,
  output logic          dm_re,
  input  logic [31:0]   dm_dout
);

  typedef enum logic [2:0] {
    IDLE,
    LD_WAIT,
    LD_CAP,
    RMW_WAIT,
    RMW_MERGE,
    ST_ACK,
    ERR
  } state_t;

  state_t state, state_d;

  logic [1:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic          uns_q, uns_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   din_d;
  logic          we_d, re_d;
  logic          rv_d, err_d;
  logic [31:0]   rd_d;
  logic [31:0]   ext;
  logic [31:0]   merged;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic          misal;
  logic          is_ld;
  logic          is_wst;
  logic          is_sst;
  logic          unused_addr;

  assign unused_addr = ^bus.req_addr[31:AW+2];
  assign bus.req_ready = (state == IDLE);

  assign misal =
    (bus.req_size == 2'b01 && bus.req_addr[0]) ||
    (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  assign is_ld  = !misal && !bus.req_we;
  assign is_wst = !misal && bus.req_we && bus.req_size[1];
  assign is_sst = !misal && bus.req_we && !bus.req_size[1];

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_b = dm_dout[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? dm_dout[31:16] : dm_dout[15:0];
    ext    = dm_dout;
    merged = dm_dout;
    unique case (1'b1)
      size_q == 2'b00: begin
        ext = {{24{~uns_q & lane_b[7]}}, lane_b};
        merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      size_q == 2'b01: begin
        ext = {{16{~uns_q & lane_h[15]}}, lane_h};
        merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end
      size_q[1]: begin
        ext = dm_dout;
      end
    endcase
  end

  // Next-state and next registered-output logic
  always_comb begin
    state_d = state;
    addr_d  = dm_addr;
    din_d   = dm_din;
    we_d    = 1'b0;
    re_d    = 1'b0;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    rd_d    = bus.resp_rdata;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          unique case (1'b1)
            misal: state_d = ERR;
            is_ld: begin
              addr_d  = bus.req_addr[AW+1:2];
              size_d  = bus.req_size;
              off_d   = bus.req_addr[1:0];
              uns_d   = bus.req_unsigned;
              re_d    = 1'b1;
              state_d = LD_WAIT;
            end
            is_wst: begin
              addr_d  = bus.req_addr[AW+1:2];
              din_d   = bus.req_wdata;
              we_d    = 1'b1;
              state_d = ST_ACK;
            end
            is_sst: begin
              addr_d  = bus.req_addr[AW+1:2];
              size_d  = bus.req_size;
              off_d   = bus.req_addr[1:0];
              wdata_d = bus.req_wdata[15:0];
              re_d    = 1'b1;
              state_d = RMW_WAIT;
            end
          endcase
        end
      end
      LD_WAIT:   state_d = LD_CAP;
      LD_CAP: begin
        rd_d    = ext;
        rv_d    = 1'b1;
        state_d = IDLE;
      end
      RMW_WAIT:  state_d = RMW_MERGE;
      RMW_MERGE: begin
        din_d   = merged;
        we_d    = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        rv_d    = 1'b1;
        rd_d    = '0;
        state_d = IDLE;
      end
      ERR: begin
        rv_d    = 1'b1;
        err_d   = 1'b1;
        rd_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Registered memory strobes, response and latched request fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_addr        <= '0;
      dm_din         <= '0;
      dm_we          <= 1'b0;
      dm_re          <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      size_q         <= '0;
      off_q          <= '0;
      uns_q          <= 1'b0;
      wdata_q        <= '0;
    end else begin
      dm_addr        <= addr_d;
      dm_din         <= din_d;
      dm_we          <= we_d;
      dm_re          <= re_d;
      bus.resp_valid <= rv_d;
      bus.resp_err   <= err_d;
      bus.resp_rdata <= rd_d;
      size_q         <= size_d;
      off_q          <= off_d;
      uns_q          <= uns_d;
      wdata_q        <= wdata_d;
    end
  end

endmodule
